// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the next-PC generator.
//   fsm_e       : fetch FSM states (HALT, RUN, BUBBLE)
//   redir_src_e : winning redirect source for the current cycle
//   INSTR_BYTES : bytes per instruction (fixed 32-bit instructions)
//   BCNT_W      : width of the refill-bubble counter (covers 0..15)
package pc_gen_pkg;

    typedef enum logic [1:0] {
        HALT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } fsm_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FLUSH = 2'd1,
        JUMP  = 2'd2,
        BP    = 2'd3
    } redir_src_e;

    localparam int INSTR_BYTES = 4;
    localparam int BCNT_W      = 4;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack used for return prediction.
// Ports:
//   clk, reset : clock, synchronous active-high reset (empties the stack)
//   push       : write push_pc as the new top
//   push_pc    : return address to push
//   pop        : remove the current top (ignored when empty)
//   top        : current top entry (meaningless when empty)
//   empty      : no valid entries
// Push and pop in the same cycle replace the top entry in place.
// Pushing when full overwrites the oldest entry (the write pointer just wraps).
module pc_ras
    import pc_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic            pop,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr_q;     // next free slot; top lives at ptr_q-1
    logic [PW:0]     cnt_q;     // number of valid entries, saturates at DEPTH
    logic [PW-1:0]   top_idx;

    assign top_idx = ptr_q - 1'b1;
    assign empty   = (cnt_q == '0);
    assign top     = mem[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push && pop && !empty) begin
            mem[top_idx] <= push_pc;
        end else if (push) begin
            mem[ptr_q] <= push_pc;
            ptr_q      <= ptr_q + 1'b1;
            if (cnt_q != FULL) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (pop && !empty) begin
            ptr_q <= ptr_q - 1'b1;
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: next-PC generator for the IF stage.
// Emits aligned fetch groups of FETCH_W 32-bit instructions and arbitrates
// redirects with priority flush > jump > predictor, inserting REDIRECT_BUBBLE
// valid-low cycles after every redirect.
// Optional feature macro: PC_RAS_EN (adds a RAS_DEPTH-entry return-address
// stack; predicted returns take their target from the stack top).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   enable_i              : 0 halts fetch
//   init_pc_i             : PC loaded on reset (bits [1:0] dropped)
//   flush_valid_i/pc_i    : backend flush request and target
//   jump_valid_i/pc_i     : decode jump request and target
//   bp_taken_i/target_i   : predictor taken flag and target for the current group
//   ras_push_i/push_pc_i  : push a return address (PC_RAS_EN only)
//   ras_pop_i             : predicted branch is a return (PC_RAS_EN only)
//   out_ready_i           : IF accepts the current group
//   out_valid_o           : pc_o / fetch_mask_o valid
//   pc_o                  : group PC, word aligned
//   fetch_mask_o          : per-lane valid for lanes at or above pc_o
//   redirect_o            : one-cycle pulse after a redirect was taken
//
// Handshake: a group transfers on a cycle where out_valid_o and out_ready_i
// are both 1. While out_valid_o=1 and out_ready_i=0, pc_o, fetch_mask_o and
// out_valid_o stay stable; only a flush or jump may change them. The
// predictor inputs are only looked at on a transfer cycle.
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int FETCH_W         = 2,
    parameter int REDIRECT_BUBBLE = 1,
    parameter int RAS_DEPTH       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_i,
    input  logic [XLEN-1:0]    init_pc_i,
    input  logic               flush_valid_i,
    input  logic [XLEN-1:0]    flush_pc_i,
    input  logic               jump_valid_i,
    input  logic [XLEN-1:0]    jump_pc_i,
    input  logic               bp_taken_i,
    input  logic [XLEN-1:0]    bp_target_i,
    input  logic               ras_push_i,
    input  logic [XLEN-1:0]    ras_push_pc_i,
    input  logic               ras_pop_i,
    input  logic               out_ready_i,
    output logic               out_valid_o,
    output logic [XLEN-1:0]    pc_o,
    output logic [FETCH_W-1:0] fetch_mask_o,
    output logic               redirect_o
);

    localparam logic [XLEN-1:0]   GROUP_BYTES = XLEN'(FETCH_W * INSTR_BYTES);
    localparam logic [XLEN-1:0]   GROUP_OFFS  = GROUP_BYTES - XLEN'(1);
    localparam logic [XLEN-1:0]   INSTR_OFFS  = XLEN'(INSTR_BYTES - 1);
    localparam logic [BCNT_W-1:0] BUBBLE_LOAD =
        (REDIRECT_BUBBLE > 0) ? BCNT_W'(REDIRECT_BUBBLE - 1) : '0;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~INSTR_OFFS;
    endfunction

    fsm_e              state_q, state_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              redirect_q, redirect_d;

    logic              handshake;
    logic              accept;
    logic              bp_fire;
    redir_src_e        redir_src;
    logic [XLEN-1:0]   redir_pc;
    logic [XLEN-1:0]   bp_pc;
    logic              ras_pop_hit;
    logic [XLEN-1:0]   ras_top;
    logic              ras_empty;

    // A transfer while enable_i is low is the in-flight group being
    // discarded, so it neither advances the PC nor consults the predictor.
    assign handshake = out_valid_o & out_ready_i;
    assign accept    = handshake & enable_i;
    assign bp_fire   = accept & bp_taken_i;

    always_comb begin
        redir_src = NONE;
        if (flush_valid_i) begin
            redir_src = FLUSH;
        end else if (jump_valid_i) begin
            redir_src = JUMP;
        end else if (bp_fire) begin
            redir_src = BP;
        end
    end

    // Only a predictor redirect that actually wins arbitration pops the stack.
    assign ras_pop_hit = (redir_src == BP) & ras_pop_i & ~ras_empty;
    assign bp_pc       = ras_pop_hit ? ras_top : bp_target_i;

`ifdef PC_RAS_EN
    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .reset   (reset),
        .push    (ras_push_i),
        .push_pc (ras_push_pc_i),
        .pop     (ras_pop_hit),
        .top     (ras_top),
        .empty   (ras_empty)
    );
`else
    logic unused_ras_cfg;
    assign ras_top        = '0;
    assign ras_empty      = 1'b1;
    assign unused_ras_cfg = ^{ras_push_i, ras_push_pc_i, (RAS_DEPTH > 0)};
`endif

    always_comb begin
        case (redir_src)
            FLUSH:   redir_pc = flush_pc_i;
            JUMP:    redir_pc = jump_pc_i;
            BP:      redir_pc = bp_pc;
            default: redir_pc = pc_q;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HALT;
            cnt_q      <= '0;
            pc_q       <= word_align(init_pc_i);
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
        end
    end

    // Next-state logic. A redirect overrides whatever the FSM would do and,
    // when taken during BUBBLE, reloads the counter from the top.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        if (redir_src != NONE) begin
            pc_d       = word_align(redir_pc);
            redirect_d = 1'b1;
            if (REDIRECT_BUBBLE > 0) begin
                state_d = BUBBLE;
                cnt_d   = BUBBLE_LOAD;
            end else begin
                state_d = enable_i ? RUN : HALT;
            end
        end else begin
            case (state_q)
                HALT: begin
                    if (enable_i) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!enable_i) begin
                        state_d = HALT;
                    end else if (accept) begin
                        pc_d = (pc_q & ~GROUP_OFFS) + GROUP_BYTES;
                    end
                end
                BUBBLE: begin
                    if (!enable_i) begin
                        state_d = HALT;
                    end else if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = HALT;
            endcase
        end
    end

    // Outputs. A lane is valid when its address is at or above pc_o within
    // the aligned group, which masks the leading lanes of an unaligned entry.
    always_comb begin
        out_valid_o  = (state_q == RUN);
        pc_o         = pc_q;
        redirect_o   = redirect_q;
        fetch_mask_o = '0;
        if (state_q == RUN) begin
            for (int i = 0; i < FETCH_W; i++) begin
                fetch_mask_o[i] =
                    ((pc_q & ~GROUP_OFFS) + XLEN'(i * INSTR_BYTES)) >= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

    localparam int XLEN    = 32;
    localparam int FETCH_W = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [XLEN-1:0]    init_pc;
    logic               flush_valid;
    logic [XLEN-1:0]    flush_pc;
    logic               jump_valid;
    logic [XLEN-1:0]    jump_pc;
    logic               bp_taken;
    logic [XLEN-1:0]    bp_target;
    logic               ras_push;
    logic [XLEN-1:0]    ras_push_pc;
    logic               ras_pop;
    logic               out_ready;
    logic               out_valid;
    logic [XLEN-1:0]    pc;
    logic [FETCH_W-1:0] fetch_mask;
    logic               redirect;

    int checks = 0;
    int errors = 0;
    logic [XLEN+FETCH_W-1:0] exp_q[$];

    pc_gen_unit #(
        .XLEN            (XLEN),
        .FETCH_W         (FETCH_W),
        .REDIRECT_BUBBLE (1),
        .RAS_DEPTH       (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (enable),
        .init_pc_i     (init_pc),
        .flush_valid_i (flush_valid),
        .flush_pc_i    (flush_pc),
        .jump_valid_i  (jump_valid),
        .jump_pc_i     (jump_pc),
        .bp_taken_i    (bp_taken),
        .bp_target_i   (bp_target),
        .ras_push_i    (ras_push),
        .ras_push_pc_i (ras_push_pc),
        .ras_pop_i     (ras_pop),
        .out_ready_i   (out_ready),
        .out_valid_o   (out_valid),
        .pc_o          (pc),
        .fetch_mask_o  (fetch_mask),
        .redirect_o    (redirect)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [XLEN-1:0] init);
        reset       = 1'b1;
        init_pc     = init;
        enable      = 1'b0;
        out_ready   = 1'b0;
        flush_valid = 1'b0;
        flush_pc    = '0;
        jump_valid  = 1'b0;
        jump_pc     = '0;
        bp_taken    = 1'b0;
        bp_target   = '0;
        ras_push    = 1'b0;
        ras_push_pc = '0;
        ras_pop     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic v, input logic [XLEN-1:0] p,
                             input logic [FETCH_W-1:0] m, input logic r);
        check({name, "_valid"}, 64'(out_valid), 64'(v));
        check({name, "_pc"}, 64'(pc), 64'(p));
        check({name, "_mask"}, 64'(fetch_mask), 64'(m));
        check({name, "_redirect"}, 64'(redirect), 64'(r));
    endtask

    // Driver side of the scoreboard: every group IF should accept
    task automatic exp_push(input logic [XLEN-1:0] p, input logic [FETCH_W-1:0] m);
        exp_q.push_back({p, m});
    endtask

    // Monitor: pops one expectation per accepted group
    task automatic monitor();
        logic [XLEN+FETCH_W-1:0] item;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_group actual=%0h/%0h expected=none", pc, fetch_mask);
                end else begin
                    item = exp_q.pop_front();
                    check("group_pc", 64'(pc), 64'(item[XLEN+FETCH_W-1:FETCH_W]));
                    check("group_mask", 64'(fetch_mask), 64'(item[FETCH_W-1:0]));
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state and sequential fetch from 0x100
        do_reset(32'h100);
        check_out("reset", 1'b0, 32'h100, 2'b00, 1'b0);
        enable = 1'b1;
        out_ready = 1'b1;
        exp_push(32'h100, 2'b11);
        tick();
        check_out("first_group", 1'b1, 32'h100, 2'b11, 1'b0);
        tick();
        out_ready = 1'b0;

        // Stall at 0x108 for 3 cycles, then resume
        for (int i = 0; i < 3; i++) begin
            check_out("stall", 1'b1, 32'h108, 2'b11, 1'b0);
            tick();
        end
        exp_push(32'h108, 2'b11);
        out_ready = 1'b1;
        tick();
        check("resume_pc", 64'(pc), 64'h110);

        // Predictor ignored without handshake, taken with one
        out_ready = 1'b0;
        bp_taken  = 1'b1;
        bp_target = 32'h500;
        tick();
        check_out("bp_no_hs", 1'b1, 32'h110, 2'b11, 1'b0);
        out_ready = 1'b1;
        bp_target = 32'h300;
        exp_push(32'h110, 2'b11);
        tick();
        check_out("bp_bubble", 1'b0, 32'h300, 2'b00, 1'b1);
        bp_taken = 1'b0;
        tick();
        check_out("bp_target", 1'b1, 32'h300, 2'b11, 1'b0);
        exp_push(32'h300, 2'b11);
        tick();
        check("bp_seq_pc", 64'(pc), 64'h308);

        // Flush + jump + bp together: flush wins
        out_ready   = 1'b0;
        flush_valid = 1'b1;
        flush_pc    = 32'h400;
        jump_valid  = 1'b1;
        jump_pc     = 32'h200;
        bp_taken    = 1'b1;
        bp_target   = 32'h600;
        tick();
        check_out("prio_bubble", 1'b0, 32'h400, 2'b00, 1'b1);
        flush_valid = 1'b0;
        jump_valid  = 1'b0;
        bp_taken    = 1'b0;
        tick();
        check_out("prio_flush", 1'b1, 32'h400, 2'b11, 1'b0);

        // Jump beats bp on a handshake; target low bits dropped
        out_ready  = 1'b1;
        jump_valid = 1'b1;
        jump_pc    = 32'h206;
        bp_taken   = 1'b1;
        bp_target  = 32'h600;
        exp_push(32'h400, 2'b11);
        tick();
        check_out("jump_bubble", 1'b0, 32'h204, 2'b00, 1'b1);
        jump_valid = 1'b0;
        bp_taken   = 1'b0;
        out_ready  = 1'b0;
        tick();
        check_out("jump_target", 1'b1, 32'h204, 2'b10, 1'b0);

        // Unaligned reset PC
        do_reset(32'h104);
        enable    = 1'b1;
        out_ready = 1'b1;
        exp_push(32'h104, 2'b10);
        exp_push(32'h108, 2'b11);
        tick();
        check_out("unaligned", 1'b1, 32'h104, 2'b10, 1'b0);
        tick();
        tick();
        out_ready = 1'b0;
        check("unaligned_seq_pc", 64'(pc), 64'h110);

        // Wrap-around, halt and re-enable
        do_reset(32'hFFFF_FFFA);
        check("wrap_reset_pc", 64'(pc), 64'hFFFF_FFF8);
        enable    = 1'b1;
        out_ready = 1'b1;
        exp_push(32'hFFFF_FFF8, 2'b11);
        tick();
        tick();
        out_ready = 1'b0;
        check_out("wrap", 1'b1, 32'h0, 2'b11, 1'b0);
        enable = 1'b0;
        tick();
        check_out("halt", 1'b0, 32'h0, 2'b00, 1'b0);
        tick();
        check_out("halt_hold", 1'b0, 32'h0, 2'b00, 1'b0);
        enable = 1'b1;
        tick();
        check_out("reenable", 1'b1, 32'h0, 2'b11, 1'b0);

        // Flush taken while halted
        enable = 1'b0;
        tick();
        flush_valid = 1'b1;
        flush_pc    = 32'h700;
        tick();
        check_out("halt_flush", 1'b0, 32'h700, 2'b00, 1'b1);
        flush_valid = 1'b0;
        tick();
        check_out("halt_flush_after", 1'b0, 32'h700, 2'b00, 1'b0);

        // Redirect during bubble restarts it
        enable     = 1'b1;
        jump_valid = 1'b1;
        jump_pc    = 32'h800;
        tick();
        check_out("restart_a", 1'b0, 32'h800, 2'b00, 1'b1);
        jump_valid  = 1'b0;
        flush_valid = 1'b1;
        flush_pc    = 32'h900;
        tick();
        check_out("restart_b", 1'b0, 32'h900, 2'b00, 1'b1);
        flush_valid = 1'b0;
        tick();
        check_out("restart_run", 1'b1, 32'h900, 2'b11, 1'b0);

        // Return prediction (stack top only with PC_RAS_EN)
        ras_push    = 1'b1;
        ras_push_pc = 32'h1234;
        tick();
        ras_push  = 1'b0;
        bp_taken  = 1'b1;
        ras_pop   = 1'b1;
        bp_target = 32'h9999;
        out_ready = 1'b1;
        exp_push(32'h900, 2'b11);
        tick();
        bp_taken  = 1'b0;
        ras_pop   = 1'b0;
        out_ready = 1'b0;
`ifdef PC_RAS_EN
        check_out("ras_bubble", 1'b0, 32'h1234, 2'b00, 1'b1);
        tick();
        check_out("ras_target", 1'b1, 32'h1234, 2'b10, 1'b0);
`else
        check_out("ras_bubble", 1'b0, 32'h9998, 2'b00, 1'b1);
        tick();
        check_out("ras_target", 1'b1, 32'h9998, 2'b11, 1'b0);
`endif

        // Drain scoreboard (bounded)
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            tick();
        end
        check("scoreboard_left", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
